// File: rtl/skew_rd_ctrl.sv
// Skewed read sequencer: lane i reads `depth` words from a shared base address, starting i cycles
// after lane 0, then pulses wr_start at cycle WR_DELAY and done at the end. Macro RD_STRIDE_EN adds a stride port.
module skew_rd_ctrl #(
    parameter int N        = 16,
    parameter int ADDR_W   = 8,
    parameter int DEPTH_W  = 8,
    parameter int WR_DELAY = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [DEPTH_W-1:0]    depth,
`ifdef RD_STRIDE_EN
    input  logic [ADDR_W-1:0]     stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [N-1:0]          rd_en,
    output logic [N*ADDR_W-1:0]   rd_addr,
    output logic                  wr_start
);

    localparam int CNT_W = $clog2(2**DEPTH_W + N + WR_DELAY + 1);

    // Handshake: start is accepted on any edge where busy=0. Once busy rises, start is ignored
    // until busy falls again. done pulses for one cycle, and busy stays high during that cycle.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     k, k_n;
    logic [CNT_W-1:0]     last_k, tail_k;
    logic [ADDR_W-1:0]    base_q, base_v;
    logic [DEPTH_W-1:0]   depth_q, depth_v;
    logic [ADDR_W-1:0]    stride_v;
    logic                 load, emit, done_n, wr_n;
    logic [N-1:0]         en_n;
    logic [N*ADDR_W-1:0]  addr_n;
    logic [CNT_W:0]       lane_off [N];

`ifdef RD_STRIDE_EN
    logic [ADDR_W-1:0]    stride_q;
    assign stride_v = load ? stride : stride_q;

    always_ff @(posedge clk) begin
        if (reset)
            stride_q <= '0;
        else if (load)
            stride_q <= stride;
    end
`else
    assign stride_v = ADDR_W'(1);
`endif

    assign base_v  = load ? base_addr : base_q;
    assign depth_v = load ? depth : depth_q;

    // Last RUN cycle: either the last lane's final read or the wr_start cycle, whichever is later.
    always_comb begin
        tail_k = CNT_W'(depth_q) + CNT_W'(N - 2);
        last_k = (tail_k > CNT_W'(WR_DELAY)) ? tail_k : CNT_W'(WR_DELAY);
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        load    = 1'b0;
        emit    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    k_n  = '0;
                    if (depth == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        emit    = 1'b1;
                    end
                end
            end
            RUN: begin
                k_n = k + CNT_W'(1);
                if (k == last_k) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                k_n     = '0;
            end
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    // Registered outputs are computed for cycle k_n. lane_off carries a borrow bit that flags k_n < i.
    always_comb begin
        en_n   = '0;
        addr_n = '0;
        for (int i = 0; i < N; i++) begin
            lane_off[i] = {1'b0, k_n} - (CNT_W+1)'(i);
            if (emit && !lane_off[i][CNT_W] && (lane_off[i][CNT_W-1:0] < CNT_W'(depth_v))) begin
                en_n[i] = 1'b1;
                addr_n[i*ADDR_W +: ADDR_W] = base_v + ADDR_W'(lane_off[i][CNT_W-1:0]) * stride_v;
            end
        end
        wr_n = emit && (depth_v != '0) && (k_n == CNT_W'(WR_DELAY));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            base_q   <= '0;
            depth_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= '0;
            rd_addr  <= '0;
            wr_start <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            if (load) begin
                base_q  <= base_addr;
                depth_q <= depth;
            end
            busy     <= (state_n != IDLE);
            done     <= done_n;
            rd_en    <= en_n;
            rd_addr  <= addr_n;
            wr_start <= wr_n;
        end
    end

endmodule

// File: tb/tb_skew_rd_ctrl.sv
// Testbench for skew_rd_ctrl: table of per-cycle vectors over captured waves, plus hand sequences
// for reset, ignored start pulses and (with RD_STRIDE_EN) strided addressing.
module tb_skew_rd_ctrl;
    localparam int N    = 16;
    localparam int AW   = 8;
    localparam int NCAP = 40;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [AW-1:0]   base_addr, stride;
    logic [7:0]      depth;
    logic            busy, done, wr_start;
    logic [N-1:0]    rd_en;
    logic [N*AW-1:0] rd_addr;

    always #5 clk = ~clk;

    skew_rd_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .depth(depth),
`ifdef RD_STRIDE_EN
        .stride(stride),
`endif
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .wr_start(wr_start)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0]    cap_en   [NCAP];
    logic [N*AW-1:0] cap_addr [NCAP];
    logic            cap_wr   [NCAP];
    logic            cap_done [NCAP];
    logic            cap_busy [NCAP];

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  dep;
        int          k;
        int          lane;
        logic [15:0] en;
        logic [7:0]  addr;
        logic        wr;
        logic        dn;
        logic        bsy;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] lane_addr(input int k, input int lane);
        logic [N*AW-1:0] v;
        v = cap_addr[k];
        return v[lane*AW +: AW];
    endfunction

    // Start a wave and record NCAP cycles (index = k). poke_k pulses start at that cycle;
    // reset_k asserts reset for the edge following that cycle.
    task automatic run_wave(input logic [7:0] b, input logic [7:0] d, input logic [7:0] s,
                            input int poke_k, input int reset_k);
        @(negedge clk);
        base_addr = b;
        depth     = d;
        stride    = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        base_addr = 8'h5A;
        depth     = 8'd7;
        stride    = 8'd3;
        for (int k = 0; k < NCAP; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start       = 1'b0;
            reset       = 1'b0;
            cap_en[k]   = rd_en;
            cap_addr[k] = rd_addr;
            cap_wr[k]   = wr_start;
            cap_done[k] = done;
            cap_busy[k] = busy;
            if (k == poke_k) begin
                start     = 1'b1;
                base_addr = 8'h80;
                depth     = 8'd2;
            end
            if (k == reset_k) reset = 1'b1;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic pulse_stats(input int from, output int wr_cnt, output int wr_pos,
                               output int dn_cnt, output int dn_pos);
        wr_cnt = 0; wr_pos = -1; dn_cnt = 0; dn_pos = -1;
        for (int k = from; k < NCAP; k++) begin
            if (cap_wr[k])   begin wr_cnt++; wr_pos = k; end
            if (cap_done[k]) begin dn_cnt++; dn_pos = k; end
        end
    endtask

    initial begin
        int wc, wp, dc, dp;
        vecs[0]  = '{8'h10, 8'd16,  0,  0, 16'h0001, 8'h10, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{8'h10, 8'd16, 15,  0, 16'hFFFF, 8'h1F, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8'h10, 8'd16, 15, 15, 16'hFFFF, 8'h10, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8'h10, 8'd16, 18,  3, 16'hFFF8, 8'h1F, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{8'h10, 8'd16, 30, 15, 16'h8000, 8'h1F, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h10, 8'd16, 31,  0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{8'h10, 8'd16, 32,  0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'd4,   3,  0, 16'h000F, 8'h03, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h00, 8'd4,   4,  4, 16'h001E, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'h00, 8'd4,  17, 14, 16'hC000, 8'h03, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h00, 8'd4,  18, 15, 16'h8000, 8'h03, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{8'h00, 8'd4,  19, 15, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{8'h00, 8'd4,  20,  0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'hFE, 8'd4,   0,  1, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{8'hFE, 8'd4,   1,  0, 16'h0003, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{8'hFE, 8'd4,   2,  0, 16'h0007, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{8'hFE, 8'd4,   3,  0, 16'h000F, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{8'hFE, 8'd4,   1,  1, 16'h0003, 8'hFE, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{8'hFE, 8'd4,   4,  1, 16'h001E, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{8'h00, 8'd0,   0,  0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{8'h00, 8'd0,   1,  0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; base_addr = '0; depth = '0; stride = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",  64'(busy),     64'd0);
        check("reset done",  64'(done),     64'd0);
        check("reset rd_en", 64'(rd_en),    64'd0);
        check("reset wr",    64'(wr_start), 64'd0);
        check("reset addr",  64'(rd_addr == '0), 64'd1);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            run_wave(vecs[i].base, vecs[i].dep, 8'd1, -1, -1);
            check($sformatf("v%0d rd_en k%0d", i, vecs[i].k), 64'(cap_en[vecs[i].k]), 64'(vecs[i].en));
            check($sformatf("v%0d lane%0d addr", i, vecs[i].lane),
                  64'(lane_addr(vecs[i].k, vecs[i].lane)), 64'(vecs[i].addr));
            check($sformatf("v%0d wr_start", i), 64'(cap_wr[vecs[i].k]),   64'(vecs[i].wr));
            check($sformatf("v%0d done", i),     64'(cap_done[vecs[i].k]), 64'(vecs[i].dn));
            check($sformatf("v%0d busy", i),     64'(cap_busy[vecs[i].k]), 64'(vecs[i].bsy));
        end

        // depth=0: never any enable or wr_start
        run_wave(8'h00, 8'd0, 8'd1, -1, -1);
        pulse_stats(0, wc, wp, dc, dp);
        check("d0 wr count", 64'(wc), 64'd0);
        check("d0 done pos", 64'(dp), 64'd0);
        check("d0 rd_en k0", 64'(cap_en[0]), 64'd0);

        // start during RUN is ignored
        run_wave(8'h10, 8'd16, 8'd1, 5, -1);
        pulse_stats(0, wc, wp, dc, dp);
        check("poke wr count", 64'(wc), 64'd1);
        check("poke wr pos",   64'(wp), 64'd18);
        check("poke done count", 64'(dc), 64'd1);
        check("poke done pos", 64'(dp), 64'd31);
        check("poke lane0 k6", 64'(lane_addr(6, 0)), 64'h16);
        check("poke lane0 k15", 64'(lane_addr(15, 0)), 64'h1F);
        check("poke busy k32", 64'(cap_busy[32]), 64'd0);
        check("poke busy k33", 64'(cap_busy[33]), 64'd0);

        // start during the DONE cycle is not queued
        run_wave(8'h10, 8'd16, 8'd1, 31, -1);
        check("dpoke busy k32", 64'(cap_busy[32]), 64'd0);
        check("dpoke busy k33", 64'(cap_busy[33]), 64'd0);

        // reset mid-wave aborts with no done or wr_start
        run_wave(8'h10, 8'd16, 8'd1, -1, 10);
        check("rst k10 rd_en", 64'(cap_en[10]),   64'h07FF);
        check("rst k11 rd_en", 64'(cap_en[11]),   64'd0);
        check("rst k11 busy",  64'(cap_busy[11]), 64'd0);
        check("rst k11 addr",  64'(cap_addr[11] == '0), 64'd1);
        pulse_stats(10, wc, wp, dc, dp);
        check("rst wr count",   64'(wc), 64'd0);
        check("rst done count", 64'(dc), 64'd0);

        run_wave(8'h10, 8'd16, 8'd1, -1, -1);
        pulse_stats(0, wc, wp, dc, dp);
        check("post-rst k15 rd_en", 64'(cap_en[15]), 64'hFFFF);
        check("post-rst lane15 k30", 64'(lane_addr(30, 15)), 64'h1F);
        check("post-rst wr pos",   64'(wp), 64'd18);
        check("post-rst done pos", 64'(dp), 64'd31);

`ifdef RD_STRIDE_EN
        run_wave(8'h00, 8'd3, 8'd2, -1, -1);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("stride lane0 k%0d", j),     64'(lane_addr(j, 0)),     64'(2 * j));
            check($sformatf("stride lane2 k%0d", j + 2), 64'(lane_addr(j + 2, 2)), 64'(2 * j));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
